// File: rtl/spi_slave_frame_rx.sv
// SPI mode-0 slave receiver: deserialises MOSI into FRAME_BYTES-byte frames (MSB first)
// while shifting a parallel reply word out on MISO; completed bytes/frames are flagged by toggles.
module spi_slave_frame_rx #(
    parameter  int FRAME_BYTES = 2,
    localparam int W           = 8 * FRAME_BYTES
) (
    input  logic         SPI_clk_x,
    input  logic         HRESETn,
    input  logic         spi_ss_n_i,
    input  logic         spi_mosi_i,
    output logic         spi_miso_o,
    input  logic [W-1:0] tx_word_i,
    output logic [W-1:0] frame_data_o,
    output logic         frame_toggle_o,
    output logic [7:0]   byte_o,
    output logic         byte_toggle_o,
    output logic [7:0]   frame_count_o,
    output logic         in_frame_o
);

    // Frame-position state is cleared by reset and also whenever the slave is deselected.
    logic frame_rst_n;
    assign frame_rst_n = HRESETn & ~spi_ss_n_i;

    logic [2:0]   bit_cnt_q,  bit_cnt_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [W-1:0] tx_shift_q, tx_shift_d;
    logic         miso_q,     miso_d;

    logic [W-1:0] rx_shift_q, rx_shift_d;
    logic [W-1:0] frame_q,    frame_d;
    logic         frame_tgl_q, frame_tgl_d;
    logic [7:0]   byte_q,     byte_d;
    logic         byte_tgl_q, byte_tgl_d;
    logic [7:0]   count_q,    count_d;

    logic selected;
    logic frame_start;
    logic byte_wrap;
    logic last_byte;
    logic frame_done;

    always_comb begin
        selected    = ~spi_ss_n_i;
        frame_start = (bit_cnt_q == 3'd0) && (byte_cnt_q == 2'd0);
        byte_wrap   = (bit_cnt_q == 3'd7);
        last_byte   = (byte_cnt_q == 2'(FRAME_BYTES - 1));
        frame_done  = byte_wrap && last_byte;

        bit_cnt_d  = bit_cnt_q + 3'd1;
        byte_cnt_d = byte_cnt_q;
        if (byte_wrap) begin
            byte_cnt_d = last_byte ? 2'd0 : byte_cnt_q + 2'd1;
        end

        // The reply word is captured on the first rising edge; its MSB already went out combinationally.
        tx_shift_d = frame_start ? (tx_word_i << 1) : (tx_shift_q << 1);
        miso_d     = tx_shift_q[W-1];

        rx_shift_d  = rx_shift_q;
        byte_d      = byte_q;
        byte_tgl_d  = byte_tgl_q;
        frame_d     = frame_q;
        frame_tgl_d = frame_tgl_q;
        count_d     = count_q;
        if (selected) begin
            rx_shift_d = {rx_shift_q[W-2:0], spi_mosi_i};
            if (byte_wrap) begin
                byte_d     = rx_shift_d[7:0];
                byte_tgl_d = ~byte_tgl_q;
            end
            if (frame_done) begin
                frame_d     = rx_shift_d;
                frame_tgl_d = ~frame_tgl_q;
                count_d     = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge SPI_clk_x or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_shift_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // MISO changes on the falling edge so the master sees a full half-period of setup.
    always_ff @(negedge SPI_clk_x or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_shift_q  <= '0;
            frame_q     <= '0;
            frame_tgl_q <= 1'b0;
            byte_q      <= '0;
            byte_tgl_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            frame_q     <= frame_d;
            frame_tgl_q <= frame_tgl_d;
            byte_q      <= byte_d;
            byte_tgl_q  <= byte_tgl_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        if (spi_ss_n_i) begin
            spi_miso_o = 1'b0;
        end else if (frame_start) begin
            spi_miso_o = tx_word_i[W-1];
        end else begin
            spi_miso_o = miso_q;
        end
    end

    assign frame_data_o   = frame_q;
    assign frame_toggle_o = frame_tgl_q;
    assign byte_o         = byte_q;
    assign byte_toggle_o  = byte_tgl_q;
    assign frame_count_o  = count_q;
    assign in_frame_o     = ~frame_start;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx: a bit-position model predicts every output,
// one compare process checks them each half SCLK period, and literal checks pin the model.
module tb_spi_slave_frame_rx;
    localparam int FB = 2;
    localparam int W  = 8 * FB;

    logic         SPI_clk_x  = 1'b0;
    logic         HRESETn    = 1'b0;
    logic         spi_ss_n_i = 1'b1;
    logic         spi_mosi_i = 1'b0;
    logic [W-1:0] tx_word_i  = '0;
    logic         spi_miso_o;
    logic [W-1:0] frame_data_o;
    logic         frame_toggle_o;
    logic [7:0]   byte_o;
    logic         byte_toggle_o;
    logic [7:0]   frame_count_o;
    logic         in_frame_o;

    spi_slave_frame_rx #(.FRAME_BYTES(FB)) dut (
        .SPI_clk_x     (SPI_clk_x),
        .HRESETn       (HRESETn),
        .spi_ss_n_i    (spi_ss_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .tx_word_i     (tx_word_i),
        .frame_data_o  (frame_data_o),
        .frame_toggle_o(frame_toggle_o),
        .byte_o        (byte_o),
        .byte_toggle_o (byte_toggle_o),
        .frame_count_o (frame_count_o),
        .in_frame_o    (in_frame_o)
    );

    int tests = 0;
    int fails = 0;

    // Model: position within the frame plus the bits seen so far.
    int           m_pos;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_tx;
    logic [W-1:0] e_frame;
    logic [7:0]   e_byte;
    logic         e_ftgl;
    logic         e_btgl;
    logic [7:0]   e_cnt;
    logic         e_miso_valid;
    logic         e_miso;
    logic [W-1:0] miso_cap;

    event ev_chk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(ev_chk) begin
        chk("frame_data", 32'(frame_data_o), 32'(e_frame));
        chk("frame_toggle", 32'(frame_toggle_o), 32'(e_ftgl));
        chk("byte", 32'(byte_o), 32'(e_byte));
        chk("byte_toggle", 32'(byte_toggle_o), 32'(e_btgl));
        chk("frame_count", 32'(frame_count_o), 32'(e_cnt));
        chk("in_frame", 32'(in_frame_o), 32'(m_pos != 0));
        if (e_miso_valid) chk("miso", 32'(spi_miso_o), 32'(e_miso));
    end

    task automatic model_reset();
        m_pos   = 0;
        m_acc   = '0;
        m_tx    = '0;
        e_frame = '0;
        e_byte  = '0;
        e_ftgl  = 1'b0;
        e_btgl  = 1'b0;
        e_cnt   = '0;
    endtask

    task automatic model_rise(input logic b);
        if (m_pos == 0) m_tx = tx_word_i;
        m_acc = {m_acc[W-2:0], b};
        m_pos++;
        if (m_pos % 8 == 0) begin
            e_byte = m_acc[7:0];
            e_btgl = ~e_btgl;
        end
        if (m_pos == W) begin
            e_frame = m_acc;
            e_ftgl  = ~e_ftgl;
            e_cnt   = e_cnt + 8'd1;
            m_pos   = 0;
        end
    endtask

    task automatic compute_miso();
        if (spi_ss_n_i)      e_miso = 1'b0;
        else if (m_pos == 0) e_miso = tx_word_i[W-1];
        else                 e_miso = m_tx[W-1-m_pos];
    endtask

    task automatic send_bit(input logic b);
        spi_mosi_i = b;
        #2;
        compute_miso();
        e_miso_valid = 1'b1;
        ->ev_chk;
        #1;
        miso_cap = {miso_cap[W-2:0], spi_miso_o};
        #2;
        SPI_clk_x = 1'b1;
        model_rise(b);
        #1;
        e_miso_valid = 1'b0;
        ->ev_chk;
        #4;
        SPI_clk_x = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d);
        miso_cap = '0;
        for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic select();
        spi_ss_n_i = 1'b0;
        #3;
        compute_miso();
        e_miso_valid = 1'b1;
        ->ev_chk;
        #2;
    endtask

    task automatic deselect();
        spi_ss_n_i = 1'b1;
        m_pos = 0;
        #2;
        compute_miso();
        e_miso_valid = 1'b1;
        ->ev_chk;
        #3;
    endtask

    task automatic reset_pulse();
        HRESETn = 1'b0;
        model_reset();
        #2;
        compute_miso();
        e_miso_valid = 1'b1;
        ->ev_chk;
        #1;
        chk("rst_frame_lit", 32'(frame_data_o), 32'h0);
        chk("rst_count_lit", 32'(frame_count_o), 32'h0);
        chk("rst_in_frame_lit", 32'(in_frame_o), 32'h0);
        chk("rst_miso_lit", 32'(spi_miso_o), 32'(spi_ss_n_i ? 1'b0 : tx_word_i[W-1]));
        HRESETn = 1'b1;
        #2;
    endtask

    initial begin
        model_reset();
        e_miso_valid = 1'b0;
        miso_cap     = '0;
        #3;
        reset_pulse();
        chk("rst_toggle_lit", 32'({frame_toggle_o, byte_toggle_o}), 32'h0);

        // Basic frame 0x11, 0x08
        select();
        send_frame(16'h1108);
        #1;
        chk("t1_frame_lit", 32'(frame_data_o), 32'h1108);
        chk("t1_ftgl_lit", 32'(frame_toggle_o), 32'h1);
        chk("t1_count_lit", 32'(frame_count_o), 32'h1);
        chk("t1_byte_lit", 32'(byte_o), 32'h08);
        chk("t1_btgl_lit", 32'(byte_toggle_o), 32'h0);
        deselect();

        // Abort after 11 bits, then a full frame
        select();
        send_byte(8'h11);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("abort_in_frame_lit", 32'(in_frame_o), 32'h1);
        deselect();
        chk("abort_dropped_lit", 32'(frame_data_o), 32'h1108);
        chk("abort_in_frame_off_lit", 32'(in_frame_o), 32'h0);
        select();
        send_frame(16'h3344);
        #1;
        chk("abort_frame_lit", 32'(frame_data_o), 32'h3344);
        chk("abort_count_lit", 32'(frame_count_o), 32'h2);
        deselect();

        // MISO reply; tx_word_i changes after capture
        tx_word_i = 16'hA5C3;
        select();
        miso_cap = '0;
        send_byte(8'h5A);
        tx_word_i = 16'h0000;
        send_byte(8'h96);
        chk("miso_word_lit", 32'(miso_cap), 32'hA5C3);
        deselect();
        chk("miso_idle_lit", 32'(spi_miso_o), 32'h0);

        // Back-to-back frames with a new reply word
        tx_word_i = 16'h1234;
        select();
        send_frame(16'h1108);
        chk("b2b_miso1_lit", 32'(miso_cap), 32'h1234);
        tx_word_i = 16'hBEEF;
        send_frame(16'h2204);
        chk("b2b_miso2_lit", 32'(miso_cap), 32'hBEEF);
        #1;
        chk("b2b_frame_lit", 32'(frame_data_o), 32'h2204);
        chk("b2b_count_lit", 32'(frame_count_o), 32'h5);
        deselect();

        // Reset mid-frame
        tx_word_i = 16'h0000;
        select();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        reset_pulse();
        deselect();
        select();
        send_frame(16'h5566);
        #1;
        chk("rst_next_frame_lit", 32'(frame_data_o), 32'h5566);
        chk("rst_next_count_lit", 32'(frame_count_o), 32'h1);
        deselect();

        // Counter wrap over 256 frames
        reset_pulse();
        select();
        for (int f = 0; f < 256; f++) send_frame(16'h0001);
        #1;
        chk("wrap_count_lit", 32'(frame_count_o), 32'h0);
        chk("wrap_ftgl_lit", 32'(frame_toggle_o), 32'h0);
        chk("wrap_frame_lit", 32'(frame_data_o), 32'h0001);
        deselect();

        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
